// File: rtl/booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM states, Booth recode pairs and the operand extension rule.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // {Q[0], q_m1} pairs that trigger an add or subtract of M
    localparam logic [1:0] REC_ADD = 2'b01;
    localparam logic [1:0] REC_SUB = 2'b10;

    // Widen a width-bit operand by one bit so a single signed engine serves both modes.
    function automatic logic [32:0] ext_operand(input logic [31:0] v,
                                                input int unsigned width,
                                                input logic        sgn);
        logic [32:0] r;
        r = '0;
        for (int i = 0; i < 33; i++) begin
            if (i < int'(width))
                r[i] = v[i];
            else
                r[i] = sgn & v[width-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M into A,
// then arithmetic right shift of {A, Q, q_m1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int W1 = 9
) (
    input  logic signed [W1-1:0] a,
    input  logic        [W1-1:0] q,
    input  logic                 q_m1,
    input  logic signed [W1-1:0] m,
    output logic signed [W1-1:0] a_next,
    output logic        [W1-1:0] q_next,
    output logic                 q_m1_next
);

    logic signed [W1-1:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            REC_ADD: sum = a + m;
            REC_SUB: sum = a - m;
            default: sum = a;
        endcase
        a_next    = sum >>> 1;
        q_next    = {sum[0], q[W1-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, with a
// start/busy/done handshake and run-time signed/unsigned mode.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   M_in,
    input  logic [WIDTH-1:0]   Q_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int W1    = WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH + 2);

    state_t state, next_state;

    logic signed [W1-1:0] acc, acc_next;
    logic        [W1-1:0] mlr, mlr_next;
    logic                 mlr_m1, mlr_m1_next;
    logic signed [W1-1:0] mcand;
    logic        [CNT_W-1:0] cnt;

    logic signed [W1-1:0] m_ext;
    logic        [W1-1:0] q_ext;

    logic load, step, finish;

    assign m_ext = W1'(ext_operand(32'(M_in), WIDTH, signed_mode));
    assign q_ext = W1'(ext_operand(32'(Q_in), WIDTH, signed_mode));

    booth_step #(.W1(W1)) u_step (
        .a         (acc),
        .q         (mlr),
        .q_m1      (mlr_m1),
        .m         (mcand),
        .a_next    (acc_next),
        .q_next    (mlr_next),
        .q_m1_next (mlr_m1_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // FIN accepts a new start just like IDLE so operations can run back to back
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CNT_W'(1))
                    next_state = FIN;
            end
            FIN: begin
                finish = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mlr    <= '0;
            mlr_m1 <= 1'b0;
            mcand  <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mlr    <= q_ext;
            mlr_m1 <= 1'b0;
            mcand  <= m_ext;
            cnt    <= CNT_W'(W1);
        end else if (step) begin
            acc    <= acc_next;
            mlr    <= mlr_next;
            mlr_m1 <= mlr_m1_next;
            cnt    <= cnt - CNT_W'(1);
        end
    end

    // The two guard bits above 2*WIDTH only carry sign and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P    <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (finish)
                P <= (2*WIDTH)'({acc, mlr});
        end
    end

endmodule
